trap_detect_unit: RTL

Parametrised synchronous-exception detector and trap sequencer for the RISC-V core. It checks fetch PC, taken-branch/jump targets and data accesses against configurable memory regions and alignment rules, and folds in decoder-reported illegal/ECALL/EBREAK events. The highest-priority cause is latched into a registered trap record that is held until the CSR unit acknowledges it, and the block then drives a fixed-length pipeline flush. It sits between decode/execute and the CSR/trap-entry logic, replacing the per-signal combinational fault flags.

---
 rtl/trap_detect_unit_pkg.sv | 46 ++++
 rtl/trap_detect_unit_if.sv | 39 +++
 rtl/trap_detect_unit_exc_addr_checker.sv | 34 +++
 rtl/trap_detect_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/trap_detect_unit_pkg.sv
// Shared definitions for the trap detect unit: mcause codes, access size
// encodings, sequencer states and the alignment masks.
// Optional build macro RVC_EN: when defined, instruction alignment is 16 bits
// (compressed ISA), otherwise 32 bits.
package trap_detect_unit_pkg;

  localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_INSTR_ACCESS     = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_ACCESS      = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_STORE_ACCESS     = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_WORD3 = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } trap_state_e;

  // Low address bits that must be zero for an instruction fetch or jump target
`ifdef RVC_EN
  localparam logic [1:0] IALIGN_MASK = 2'b01;
`else
  localparam logic [1:0] IALIGN_MASK = 2'b11;
`endif

  // Low address bits that must be zero for a data access of the given size
  function automatic logic [1:0] data_align_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 2'b00;
      SZ_HALF: return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/trap_detect_unit_if.sv
// Bundle of decode/execute inputs and trap record outputs for the trap
// detect unit. The slave side is the detector, the master side its driver.
interface trap_detect_unit_if #(
  parameter int XLEN = 32
);
  logic            instr_valid_i;
  logic [XLEN-1:0] pc_i;
  logic [31:0]     instr_i;
  logic            illegal_i;
  logic            ecall_i;
  logic            ebreak_i;
  logic            jump_taken_i;
  logic [XLEN-1:0] target_pc_i;
  logic            mem_valid_i;
  logic            mem_store_i;
  logic [1:0]      mem_size_i;
  logic [XLEN-1:0] mem_addr_i;
  logic            trap_ack_i;
  logic            trap_valid_o;
  logic [3:0]      trap_cause_o;
  logic [XLEN-1:0] trap_tval_o;
  logic [XLEN-1:0] trap_pc_o;
  logic            stall_o;
  logic            flush_o;

  modport master (
    output instr_valid_i, pc_i, instr_i, illegal_i, ecall_i, ebreak_i,
           jump_taken_i, target_pc_i, mem_valid_i, mem_store_i, mem_size_i,
           mem_addr_i, trap_ack_i,
    input  trap_valid_o, trap_cause_o, trap_tval_o, trap_pc_o, stall_o, flush_o
  );

  modport slave (
    input  instr_valid_i, pc_i, instr_i, illegal_i, ecall_i, ebreak_i,
           jump_taken_i, target_pc_i, mem_valid_i, mem_store_i, mem_size_i,
           mem_addr_i, trap_ack_i,
    output trap_valid_o, trap_cause_o, trap_tval_o, trap_pc_o, stall_o, flush_o
  );
endinterface

// File: rtl/trap_detect_unit_exc_addr_checker.sv
// Combinational address checker: membership in up to two regions plus an
// alignment test against a caller-supplied mask of low bits.
module exc_addr_checker #(
  parameter int              XLEN   = 32,
  parameter logic [XLEN-1:0] BASE_A = '0,
  parameter logic [XLEN-1:0] SIZE_A = '0,
  parameter logic [XLEN-1:0] BASE_B = '0,
  parameter logic [XLEN-1:0] SIZE_B = '0,
  parameter bit              USE_B  = 1'b0
) (
  input  logic [XLEN-1:0] i_addr,
  input  logic [1:0]      i_align_mask,
  output logic            o_in_range,
  output logic            o_misaligned
);

  // One extra bit keeps base+size from wrapping at the top of the address space
  logic [XLEN:0] w_addr_ext;
  logic [XLEN:0] w_end_a;
  logic [XLEN:0] w_end_b;
  logic          w_in_a;
  logic          w_in_b;

  assign w_addr_ext = {1'b0, i_addr};
  assign w_end_a    = {1'b0, BASE_A} + {1'b0, SIZE_A};
  assign w_end_b    = {1'b0, BASE_B} + {1'b0, SIZE_B};

  assign w_in_a = (w_addr_ext >= {1'b0, BASE_A}) && (w_addr_ext < w_end_a);
  assign w_in_b = (w_addr_ext >= {1'b0, BASE_B}) && (w_addr_ext < w_end_b);

  assign o_in_range   = w_in_a | (USE_B & w_in_b);
  assign o_misaligned = |(i_addr[1:0] & i_align_mask);

endmodule

// File: rtl/trap_detect_unit.sv
// Synchronous-exception detector and trap sequencer. Picks the highest
// priority fault among fetch, decoder flags, jump target and data access,
// latches it as a trap record, holds it until acknowledged, then flushes.
// Optional build macro RVC_EN: relaxes fetch/target alignment to 16 bits.
module trap_detect_unit
  import trap_detect_unit_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] MEM_BASE     = 32'h8000_0000,
  parameter logic [XLEN-1:0] MEM_SIZE     = 32'h0002_0000,
  parameter logic [XLEN-1:0] IO_BASE      = 32'h2000_0000,
  parameter logic [XLEN-1:0] IO_SIZE      = 32'h0000_1000,
  parameter int              DRAIN_CYCLES = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  trap_detect_unit_if.slave bus
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  logic w_fetch_in, w_fetch_mis;
  logic w_tgt_in, w_tgt_mis;
  logic w_data_in, w_data_mis;

  logic            w_exc;
  logic [3:0]      w_cause;
  logic [XLEN-1:0] w_tval;

  trap_state_e     r_state;
  logic [3:0]      r_cnt;
  logic            r_valid;
  logic            r_stall;
  logic            r_flush;
  logic [3:0]      r_cause;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_pc;

  exc_addr_checker #(
    .XLEN(XLEN), .BASE_A(MEM_BASE), .SIZE_A(MEM_SIZE),
    .BASE_B(IO_BASE), .SIZE_B(IO_SIZE), .USE_B(1'b0)
  ) u_fetch_chk (
    .i_addr(bus.pc_i), .i_align_mask(IALIGN_MASK),
    .o_in_range(w_fetch_in), .o_misaligned(w_fetch_mis)
  );

  exc_addr_checker #(
    .XLEN(XLEN), .BASE_A(MEM_BASE), .SIZE_A(MEM_SIZE),
    .BASE_B(IO_BASE), .SIZE_B(IO_SIZE), .USE_B(1'b0)
  ) u_target_chk (
    .i_addr(bus.target_pc_i), .i_align_mask(IALIGN_MASK),
    .o_in_range(w_tgt_in), .o_misaligned(w_tgt_mis)
  );

  exc_addr_checker #(
    .XLEN(XLEN), .BASE_A(MEM_BASE), .SIZE_A(MEM_SIZE),
    .BASE_B(IO_BASE), .SIZE_B(IO_SIZE), .USE_B(1'b1)
  ) u_data_chk (
    .i_addr(bus.mem_addr_i), .i_align_mask(data_align_mask(bus.mem_size_i)),
    .o_in_range(w_data_in), .o_misaligned(w_data_mis)
  );

  // Priority encode the candidate exceptions into one cause/tval pair
  always_comb begin
    w_exc   = 1'b1;
    w_cause = CAUSE_INSTR_MISALIGNED;
    w_tval  = '0;
    if (bus.instr_valid_i && !w_fetch_in) begin
      w_cause = CAUSE_INSTR_ACCESS;
      w_tval  = bus.pc_i;
    end else if (bus.instr_valid_i && w_fetch_mis) begin
      w_cause = CAUSE_INSTR_MISALIGNED;
      w_tval  = bus.pc_i;
    end else if (bus.instr_valid_i && bus.illegal_i) begin
      w_cause = CAUSE_ILLEGAL_INSTR;
      w_tval  = XLEN'(bus.instr_i);
    end else if (bus.instr_valid_i && bus.ebreak_i) begin
      w_cause = CAUSE_BREAKPOINT;
      w_tval  = bus.pc_i;
    end else if (bus.instr_valid_i && bus.ecall_i) begin
      w_cause = CAUSE_ECALL_M;
    end else if (bus.jump_taken_i && w_tgt_mis) begin
      w_cause = CAUSE_INSTR_MISALIGNED;
      w_tval  = bus.target_pc_i;
    end else if (bus.jump_taken_i && !w_tgt_in) begin
      w_cause = CAUSE_INSTR_ACCESS;
      w_tval  = bus.target_pc_i;
    end else if (bus.mem_valid_i && !bus.mem_store_i && w_data_mis) begin
      w_cause = CAUSE_LOAD_MISALIGNED;
      w_tval  = bus.mem_addr_i;
    end else if (bus.mem_valid_i && !bus.mem_store_i && !w_data_in) begin
      w_cause = CAUSE_LOAD_ACCESS;
      w_tval  = bus.mem_addr_i;
    end else if (bus.mem_valid_i && bus.mem_store_i && w_data_mis) begin
      w_cause = CAUSE_STORE_MISALIGNED;
      w_tval  = bus.mem_addr_i;
    end else if (bus.mem_valid_i && bus.mem_store_i && !w_data_in) begin
      w_cause = CAUSE_STORE_ACCESS;
      w_tval  = bus.mem_addr_i;
    end else begin
      w_exc = 1'b0;
    end
  end

  // Trap sequencer: capture in IDLE, hold until ack, then fixed-length flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_stall <= 1'b0;
      r_flush <= 1'b0;
      r_cause <= '0;
      r_tval  <= '0;
      r_pc    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_exc) begin
            r_state <= ST_HOLD;
            r_valid <= 1'b1;
            r_stall <= 1'b1;
            r_cause <= w_cause;
            r_tval  <= w_tval;
            r_pc    <= bus.pc_i;
          end
        end
        ST_HOLD: begin
          if (bus.trap_ack_i) begin
            r_state <= ST_DRAIN;
            r_valid <= 1'b0;
            r_flush <= 1'b1;
            r_cnt   <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_IDLE;
            r_flush <= 1'b0;
            r_stall <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_stall <= 1'b0;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trap_valid_o = r_valid;
  assign bus.trap_cause_o = r_cause;
  assign bus.trap_tval_o  = r_tval;
  assign bus.trap_pc_o    = r_pc;
  assign bus.stall_o      = r_stall;
  assign bus.flush_o      = r_flush;

endmodule
